// File: rtl/fetch_unit.sv
// 6502 fetch sequencer: reads 1-3 byte instructions from byte-wide sync memory; FETCH_VECTOR_EN adds a reset-vector load from FFFC/FFFD.
// Latency REQ_OP->instr_valid 2/4/6 cycles for 1/2/3 bytes; valid/ready backpressure holds all outputs with mem_rd=0.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [3:0] {
    VEC_LO_REQ,
    VEC_LO_WAIT,
    VEC_HI_REQ,
    VEC_HI_WAIT,
    REQ_OP,
    WAIT_OP,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    HOLD
  } state_t;

`ifdef FETCH_VECTOR_EN
  localparam state_t      RESET_STATE = VEC_LO_REQ;
  localparam logic [15:0] PC_INIT     = 16'h0000;
`else
  localparam state_t      RESET_STATE = REQ_OP;
  localparam logic [15:0] PC_INIT     = RESET_PC;
`endif

  // Must agree with the decoder's instr_size table.
  function automatic logic [1:0] len_of(input logic [7:0] op);
    case (op)
      8'hA9, 8'hA5, 8'h85, 8'h69, 8'hE9, 8'h29: len_of = 2'd2;
      8'h4C:                                    len_of = 2'd3;
      default:                                  len_of = 2'd1;
    endcase
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic        mem_rd_q;
  logic        rd_req;
  logic [15:0] rd_addr;

  // A redirect landing on a request cycle would otherwise issue a read in the
  // very next cycle; mem_rd_q holds the request off for one cycle, which also
  // lets the aborted read's data drain unused.
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    rd_addr   = pc;
    case (state)
      VEC_LO_REQ: begin
        rd_addr = 16'hFFFC;
        if (!mem_rd_q) begin
          rd_req    = 1'b1;
          state_nxt = VEC_LO_WAIT;
        end
      end
      VEC_LO_WAIT: state_nxt = VEC_HI_REQ;
      VEC_HI_REQ: begin
        rd_addr = 16'hFFFD;
        if (!mem_rd_q) begin
          rd_req    = 1'b1;
          state_nxt = VEC_HI_WAIT;
        end
      end
      VEC_HI_WAIT: state_nxt = REQ_OP;
      REQ_OP: begin
        if (!mem_rd_q) begin
          rd_req    = 1'b1;
          state_nxt = WAIT_OP;
        end
      end
      WAIT_OP: state_nxt = (len_of(mem_rdata) == 2'd1) ? HOLD : REQ_LO;
      REQ_LO: begin
        if (!mem_rd_q) begin
          rd_req    = 1'b1;
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: state_nxt = (instr_len == 2'd3) ? REQ_HI : HOLD;
      REQ_HI: begin
        if (!mem_rd_q) begin
          rd_req    = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: state_nxt = HOLD;
      HOLD: begin
        if (instr_ready) state_nxt = REQ_OP;
      end
      default: state_nxt = REQ_OP;
    endcase
    if (redirect_valid) state_nxt = REQ_OP;
  end

  assign mem_rd   = rd_req & ~rst;
  assign mem_addr = mem_rd ? rd_addr : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESET_STATE;
      pc          <= PC_INIT;
      mem_rd_q    <= 1'b0;
      instr_valid <= 1'b0;
      opcode      <= 8'h00;
      operand     <= 16'h0000;
      instr_len   <= 2'd1;
      instr_pc    <= 16'h0000;
    end else begin
      state       <= state_nxt;
      mem_rd_q    <= mem_rd;
      instr_valid <= (state_nxt == HOLD);
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else begin
        case (state)
          VEC_LO_WAIT: pc[7:0]  <= mem_rdata;
          VEC_HI_WAIT: pc[15:8] <= mem_rdata;
          REQ_OP: begin
            if (rd_req) begin
              instr_pc <= pc;
              operand  <= 16'h0000;
            end
          end
          WAIT_OP: begin
            opcode    <= mem_rdata;
            instr_len <= len_of(mem_rdata);
            pc        <= pc + 16'd1;
          end
          WAIT_LO: begin
            operand[7:0] <= mem_rdata;
            pc           <= pc + 16'd1;
          end
          WAIT_HI: begin
            operand[15:8] <= mem_rdata;
            pc            <= pc + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer for the 6502 softcore. It reads opcode and operand bytes from byte-wide synchronous memory and assembles one complete instruction of 1-3 bytes.
- It presents {opcode, operand, length, pc} to the decode stage over a valid/ready handshake.
- It is the producer side of the decoder's opcode input. Its length table must agree with the decoder's instr_size.
- The core redirects the PC through a one-cycle redirect port (JMP).

Parameters:
- RESET_PC, 16'h0200: PC loaded on reset (when FETCH_VECTOR_EN is undefined).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_rd  out  1  read strobe, one cycle per byte
- mem_addr  out  16  read address, valid when mem_rd=1
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd
- instr_valid  out  1  assembled instruction available
- instr_ready  in  1  decode stage accepts instruction
- opcode  out  8  opcode byte
- operand  out  16  {hi,lo}; unfetched bytes are 0
- instr_len  out  2  1, 2 or 3
- instr_pc  out  16  address of opcode byte
- redirect_valid  in  1  load new PC, abort current fetch
- redirect_pc  in  16  redirect target

Behaviour:
- Length table:
  - A9, A5, 85, 69, E9, 29 -> 2
  - 4C -> 3
  - E8 and every other opcode (illegal/NOP) -> 1
- Reset (async):
  - pc=RESET_PC; state=REQ_OP.
  - mem_rd=0, mem_addr=0, instr_valid=0, opcode=0, operand=0, instr_len=1, instr_pc=0.
  - The first mem_rd is asserted in the first cycle after rst deasserts.
- States:
  - REQ_OP: mem_rd=1, mem_addr=pc; instr_pc<=pc, operand<=0; -> WAIT_OP.
  - WAIT_OP: opcode<=mem_rdata, instr_len<=table(mem_rdata), pc<=pc+1. Go to REQ_LO if len>1, else HOLD.
  - REQ_LO: mem_rd=1, mem_addr=pc; -> WAIT_LO.
  - WAIT_LO: operand[7:0]<=mem_rdata, pc<=pc+1. Go to REQ_HI if len==3, else HOLD.
  - REQ_HI: mem_rd=1, mem_addr=pc; -> WAIT_HI.
  - WAIT_HI: operand[15:8]<=mem_rdata, pc<=pc+1; -> HOLD.
  - HOLD: instr_valid=1 (registered). On instr_ready: instr_valid<=0, -> REQ_OP.
- Latency from REQ_OP to instr_valid: 2 cycles for 1 byte, 4 cycles for 2 bytes, 6 cycles for 3 bytes.
- Back-to-back throughput: the next REQ_OP is in the cycle after acceptance.
- Backpressure: in HOLD with instr_ready=0, all outputs are held stable and mem_rd=0.
- instr_valid and all instruction outputs change only on acceptance, redirect or reset.
- Redirect (any state): pc<=redirect_pc, instr_valid<=0, state<=REQ_OP.
  - Read data returning for an aborted request is discarded.
  - No instruction from the old stream becomes valid after the redirect cycle.
- Redirect together with HOLD and instr_ready in the same cycle: the handshake completes (instruction consumed) and the redirect applies. The next mem_addr is redirect_pc.
- Redirect in a REQ_* cycle: that cycle's mem_rd still fires and its data is ignored.
- PC arithmetic is 16-bit modulo: FFFF+1=0000. Operands may straddle the wrap.
- mem_rd is never asserted in two consecutive cycles.

Optional Feature:
- Macro: FETCH_VECTOR_EN.
- Defined: after reset, states VEC_LO_REQ/VEC_LO_WAIT/VEC_HI_REQ/VEC_HI_WAIT read FFFC then FFFD (each req + wait). pc is then loaded with {[FFFD],[FFFC]} and the unit enters REQ_OP; first opcode fetch is 4 cycles after reset release. RESET_PC is unused. Redirect during vector fetch aborts the vector fetch and uses redirect_pc.
- Undefined: pc=RESET_PC and no vector reads.

Test Plan:
- Reset; mem[0200]=A9, mem[0201]=05; ready=1 -> instr_valid 4 cycles after first mem_rd; opcode=A9, operand=0005, len=2, pc=0200. Next mem_addr=0202.
- mem[0202]=E8 -> valid 2 cycles after REQ_OP; opcode=E8, operand=0000, len=1. Next fetch at 0203.
- mem[0203..0205]=4C 34 12 -> operand=1234, len=3. Core pulses redirect_pc=1234 with acceptance -> next mem_addr=1234, no spurious valid.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> outputs stable, mem_rd=0 throughout. Accept -> REQ_OP next cycle.
- Redirect to 3000 in WAIT_LO of a 2-byte fetch -> instr_valid stays 0. Next mem_rd has addr=3000 and the old operand byte is never presented.
- Wrap: redirect to FFFF, mem[FFFF]=69, mem[0000]=7F -> operand=007F, instr_pc=FFFF, next fetch 0001. With FETCH_VECTOR_EN and mem[FFFC]=00, mem[FFFD]=80 -> first opcode fetch at 8000.
